// File: rtl/histogram_cdf_generator.sv
`default_nettype none
// ============================================================================
// Module   : histogram_cdf_generator
// Purpose  : Builds the pixel-intensity histogram of a frame, then a prefix-sum
//            CDF pass with CDF_min. Optional macro HIST_ERR_EN adds hist_error.
// Revision : 1.0 - initial release
// ============================================================================
module histogram_cdf_generator #(
   parameter int IMAGE_WIDTH              = 320,
   parameter int IMAGE_HEIGHT             = 240,
   parameter int PIXEL_WIDTH              = 8,
   parameter int HISTOGRAM_RAM_DATA_WIDTH = 17
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                pixel_valid,
   output logic                                pixel_ready,
   input  logic [PIXEL_WIDTH-1:0]              pixel_data,
   output logic                                histogram_generated,
   output logic                                CDF_generated,
   output logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] CDF_min,
   output logic                                is_histogram_RAM_available,
   input  logic                                rd_en,
   input  logic                                rd_sel,
   input  logic [PIXEL_WIDTH-1:0]              rd_addr,
   output logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] rd_data
`ifdef HIST_ERR_EN
   ,
   output logic                                hist_error
`endif
);

   localparam int c_DW   = HISTOGRAM_RAM_DATA_WIDTH;
   localparam int c_PW   = PIXEL_WIDTH;
   localparam int c_IW   = PIXEL_WIDTH + 1;
   localparam int c_BINS = 1 << PIXEL_WIDTH;

   localparam logic [c_DW-1:0] c_LAST_PIX      = c_DW'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
   localparam logic [c_DW-1:0] c_DATA_ONE      = c_DW'(1);
   localparam logic [c_IW-1:0] c_IDX_STEP      = c_IW'(1);
   localparam logic [c_IW-1:0] c_IDX_CLEAR_END = c_IW'(c_BINS - 1);
   localparam logic [c_IW-1:0] c_IDX_DRAIN_END = c_IW'(1);
   localparam logic [c_IW-1:0] c_IDX_CDF_END   = c_IW'(c_BINS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_ACCUM = 3'd2,
      S_DRAIN = 3'd3,
      S_CDF   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_start_ok;
   logic              w_accept;
   logic [c_IW-1:0]   r_idx;
   logic [c_DW-1:0]   r_pix_cnt;

   logic [c_DW-1:0]   r_hist_mem [c_BINS];
   logic [c_DW-1:0]   r_cdf_mem  [c_BINS];
   logic [c_DW-1:0]   r_hist_q;

   logic              r_s1_valid;
   logic [c_PW-1:0]   r_s1_addr;
   logic              r_wb_valid;
   logic [c_PW-1:0]   r_wb_addr;
   logic [c_DW-1:0]   r_wb_data;
   logic [c_DW-1:0]   w_hist_cur;
   logic [c_DW-1:0]   w_hist_inc;

   logic              r_cdf_vld;
   logic [c_PW-1:0]   r_cdf_addr;
   logic [c_DW-1:0]   r_acc;
   logic [c_DW-1:0]   w_cdf_sum;
   logic              r_min_found;

   logic              w_hist_we;
   logic [c_PW-1:0]   w_hist_waddr;
   logic [c_DW-1:0]   w_hist_wdata;
   logic              w_cdf_we;
   logic [c_PW-1:0]   w_cdf_waddr;
   logic [c_DW-1:0]   w_cdf_wdata;
   logic [c_PW-1:0]   w_hist_raddr;

   assign pixel_ready = (r_state == S_ACCUM);
   assign w_accept    = pixel_valid & pixel_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_start_ok = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_next     = S_CLEAR;
               w_start_ok = 1'b1;
            end
         end
         S_CLEAR: if (r_idx == c_IDX_CLEAR_END) w_next = S_ACCUM;
         S_ACCUM: if (w_accept && (r_pix_cnt == c_LAST_PIX)) w_next = S_DRAIN;
         S_DRAIN: if (r_idx == c_IDX_DRAIN_END) w_next = S_CDF;
         S_CDF:   if (r_idx == c_IDX_CDF_END) w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Write from one cycle ago is invisible to this cycle's sync read; forward it.
   assign w_hist_cur = (r_wb_valid && (r_wb_addr == r_s1_addr)) ? r_wb_data : r_hist_q;
   assign w_hist_inc = w_hist_cur + c_DATA_ONE;
   assign w_cdf_sum  = r_acc + r_hist_q;

   assign w_hist_raddr = (r_state == S_CDF) ? r_idx[c_PW-1:0] : pixel_data;

   always_comb begin
      w_hist_we    = 1'b0;
      w_hist_waddr = r_s1_addr;
      w_hist_wdata = w_hist_inc;
      w_cdf_we     = r_cdf_vld;
      w_cdf_waddr  = r_cdf_addr;
      w_cdf_wdata  = w_cdf_sum;
      if (r_state == S_CLEAR) begin
         w_hist_we    = 1'b1;
         w_hist_waddr = r_idx[c_PW-1:0];
         w_hist_wdata = '0;
         w_cdf_we     = 1'b1;
         w_cdf_waddr  = r_idx[c_PW-1:0];
         w_cdf_wdata  = '0;
      end else if (r_s1_valid) begin
         w_hist_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_hist_we) r_hist_mem[w_hist_waddr] <= w_hist_wdata;
      if (w_cdf_we)  r_cdf_mem[w_cdf_waddr]   <= w_cdf_wdata;
      r_hist_q <= r_hist_mem[w_hist_raddr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx       <= '0;
         r_pix_cnt   <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_addr   <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_addr   <= '0;
         r_wb_data   <= '0;
         r_cdf_vld   <= 1'b0;
         r_cdf_addr  <= '0;
         r_acc       <= '0;
         r_min_found <= 1'b0;
      end else begin
         r_idx      <= (w_next != r_state) ? '0 : r_idx + c_IDX_STEP;
         r_s1_valid <= w_accept;
         r_s1_addr  <= pixel_data;
         r_wb_valid <= r_s1_valid;
         r_wb_addr  <= r_s1_addr;
         r_wb_data  <= w_hist_inc;
         r_cdf_vld  <= (r_state == S_CDF) && (r_idx < c_IDX_CDF_END);
         r_cdf_addr <= r_idx[c_PW-1:0];
         if (w_start_ok) begin
            r_pix_cnt   <= '0;
            r_acc       <= '0;
            r_min_found <= 1'b0;
         end else begin
            if (w_accept) r_pix_cnt <= r_pix_cnt + c_DATA_ONE;
            if (r_cdf_vld) begin
               r_acc <= w_cdf_sum;
               if (w_cdf_sum != '0) r_min_found <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         histogram_generated        <= 1'b0;
         CDF_generated              <= 1'b0;
         is_histogram_RAM_available <= 1'b0;
         CDF_min                    <= '0;
      end else if (w_start_ok) begin
         histogram_generated        <= 1'b0;
         CDF_generated              <= 1'b0;
         is_histogram_RAM_available <= 1'b0;
         CDF_min                    <= '0;
      end else begin
         if ((r_state == S_DRAIN) && (w_next == S_CDF)) histogram_generated <= 1'b1;
         if ((r_state == S_CDF) && (w_next == S_DONE)) begin
            CDF_generated              <= 1'b1;
            is_histogram_RAM_available <= 1'b1;
         end
         if (r_cdf_vld && !r_min_found && (w_cdf_sum != '0)) CDF_min <= w_cdf_sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_data <= '0;
      else if (rd_en && is_histogram_RAM_available)
         rd_data <= rd_sel ? r_cdf_mem[rd_addr] : r_hist_mem[rd_addr];
      else
         rd_data <= '0;
   end

`ifdef HIST_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hist_error <= 1'b0;
      else if (w_start_ok)
         hist_error <= 1'b0;
      else if ((start && (r_state inside {S_CLEAR, S_ACCUM, S_DRAIN, S_CDF})) ||
               (pixel_valid && (r_state inside {S_DRAIN, S_CDF, S_DONE})))
         hist_error <= 1'b1;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_histogram_cdf_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_histogram_cdf_generator
// Purpose  : Directed frames with a read-port scoreboard for histogram_cdf_generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_histogram_cdf_generator;

   localparam int c_PW = 8;
   localparam int c_DW = 7;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            pixel_valid = 1'b0;
   logic            pixel_ready;
   logic [c_PW-1:0] pixel_data = '0;
   logic            histogram_generated;
   logic            CDF_generated;
   logic [c_DW-1:0] CDF_min;
   logic            is_histogram_RAM_available;
   logic            rd_en = 1'b0;
   logic            rd_sel = 1'b0;
   logic [c_PW-1:0] rd_addr = '0;
   logic [c_DW-1:0] rd_data;
`ifdef HIST_ERR_EN
   logic            hist_error;
`endif

   int checks = 0;
   int errors = 0;
   logic [c_DW-1:0] q_exp[$];
   string           q_nm[$];
   logic            rd_issued = 1'b0;
   logic [7:0]      pix [64];
   int              lat;

   histogram_cdf_generator #(
      .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .PIXEL_WIDTH(c_PW), .HISTOGRAM_RAM_DATA_WIDTH(c_DW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready), .pixel_data(pixel_data),
      .histogram_generated(histogram_generated), .CDF_generated(CDF_generated),
      .CDF_min(CDF_min), .is_histogram_RAM_available(is_histogram_RAM_available),
      .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef HIST_ERR_EN
      , .hist_error(hist_error)
`endif
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: one expectation consumed per issued read.
   always @(posedge clk) rd_issued <= rd_en;
   always @(negedge clk) begin
      if (rd_issued) begin
         checks++;
         if (q_exp.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: rd_data=%0d with no expectation queued", rd_data);
         end else begin
            logic [c_DW-1:0] e;
            string           n;
            e = q_exp.pop_front();
            n = q_nm.pop_front();
            if (rd_data !== e) begin
               errors++;
               $display("FAIL %s: rd_data=%0d expected %0d", n, rd_data, e);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic rd(input logic sel, input logic [7:0] a, input logic [c_DW-1:0] e, input string nm);
      rd_en   = 1'b1;
      rd_sel  = sel;
      rd_addr = a;
      q_exp.push_back(e);
      q_nm.push_back(nm);
      @(negedge clk);
   endtask

   task automatic rd_idle();
      rd_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic start_frame(input bit chk_drop);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (chk_drop) begin
         chk("start_drop_hist_gen", histogram_generated, 0);
         chk("start_drop_cdf_gen", CDF_generated, 0);
         chk("start_drop_avail", is_histogram_RAM_available, 0);
         chk("start_drop_cdf_min", CDF_min, 0);
      end
   endtask

   task automatic send(input int n, input bit toggle, input int start_at, input bit chk_drop);
      int t;
      t = 0;
      while (!pixel_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!pixel_ready) begin
         checks++;
         errors++;
         $display("FAIL accum_entry: pixel_ready=0 after %0d cycles, expected 1", t);
         return;
      end
      for (int i = 0; i < n; i++) begin
         pixel_valid = 1'b1;
         pixel_data  = pix[i];
         start       = (i == start_at);
         @(negedge clk);
         start = 1'b0;
         if (toggle && i != n - 1) begin
            pixel_valid = 1'b0;
            @(negedge clk);
         end
      end
      pixel_valid = 1'b0;
      if (chk_drop) chk("ready_drop_after_last", pixel_ready, 0);
   endtask

   task automatic wait_done(output int k);
      k = 0;
      while (!CDF_generated && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("cdf_generated_reached", CDF_generated, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_pixel_ready", pixel_ready, 0);
      chk("rst_hist_gen", histogram_generated, 0);
      chk("rst_cdf_gen", CDF_generated, 0);
      chk("rst_avail", is_histogram_RAM_available, 0);
      chk("rst_cdf_min", CDF_min, 0);
      chk("rst_rd_data", rd_data, 0);
      rst = 1'b0;
      @(negedge clk);

      // Frame 1: all 0x40, back to back; latency last accept -> CDF_generated
      for (int i = 0; i < 64; i++) pix[i] = 8'h40;
      start_frame(1'b0);
      send(64, 1'b0, -1, 1'b1);
      wait_done(lat);
      chk("f1_latency", lat, 259);
      chk("f1_hist_gen", histogram_generated, 1);
      chk("f1_avail", is_histogram_RAM_available, 1);
      chk("f1_cdf_min", CDF_min, 64);
      rd(1'b0, 8'h40, 7'd64, "f1_hist_40");
      rd(1'b0, 8'h3F, 7'd0,  "f1_hist_3f");
      rd(1'b0, 8'h41, 7'd0,  "f1_hist_41");
      rd(1'b0, 8'hFF, 7'd0,  "f1_hist_ff");
      rd(1'b1, 8'h3F, 7'd0,  "f1_cdf_3f");
      rd(1'b1, 8'h40, 7'd64, "f1_cdf_40");
      rd(1'b1, 8'hFF, 7'd64, "f1_cdf_ff");
      rd_idle();
      chk("f1_rd_idle_zero", rd_data, 0);

      // Frame 2: ramp 0..63 with alternating bubbles
      for (int i = 0; i < 64; i++) pix[i] = 8'(i);
      start_frame(1'b1);
      send(64, 1'b1, -1, 1'b1);
      wait_done(lat);
      chk("f2_latency", lat, 259);
      chk("f2_cdf_min", CDF_min, 1);
      rd(1'b0, 8'h00, 7'd1,  "f2_hist_00");
      rd(1'b0, 8'h3F, 7'd1,  "f2_hist_3f");
      rd(1'b0, 8'h40, 7'd0,  "f2_hist_40");
      rd(1'b1, 8'h00, 7'd1,  "f2_cdf_00");
      rd(1'b1, 8'h1F, 7'd32, "f2_cdf_1f");
      rd(1'b1, 8'h3F, 7'd64, "f2_cdf_3f");
      rd(1'b1, 8'hFF, 7'd64, "f2_cdf_ff");
      rd_idle();

      // Frame 3: 0x10,0x10,0x20,0x10 repeated; read while CDF pass runs
      for (int i = 0; i < 64; i++) pix[i] = ((i % 4) == 2) ? 8'h20 : 8'h10;
      start_frame(1'b1);
      send(64, 1'b0, -1, 1'b1);
      repeat (20) @(negedge clk);
      rd(1'b0, 8'h10, 7'd0, "f3_rd_unavailable");
      rd_idle();
      wait_done(lat);
      chk("f3_cdf_min", CDF_min, 48);
      rd(1'b0, 8'h10, 7'd48, "f3_hist_10");
      rd(1'b0, 8'h20, 7'd16, "f3_hist_20");
      rd(1'b1, 8'h0F, 7'd0,  "f3_cdf_0f");
      rd(1'b1, 8'h1F, 7'd48, "f3_cdf_1f");
      rd(1'b1, 8'h20, 7'd64, "f3_cdf_20");
      rd_idle();

      // Frame 4: abandon after 20 pixels with async reset, then 64 x 0xFF
      for (int i = 0; i < 64; i++) pix[i] = 8'h80;
      start_frame(1'b1);
      send(20, 1'b0, -1, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_pixel_ready", pixel_ready, 0);
      chk("arst_hist_gen", histogram_generated, 0);
      chk("arst_cdf_gen", CDF_generated, 0);
      chk("arst_avail", is_histogram_RAM_available, 0);
      chk("arst_cdf_min", CDF_min, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 64; i++) pix[i] = 8'hFF;
      start_frame(1'b0);
      send(64, 1'b0, -1, 1'b1);
      wait_done(lat);
      chk("f4_cdf_min", CDF_min, 64);
      rd(1'b0, 8'hFF, 7'd64, "f4_hist_ff");
      rd(1'b0, 8'h80, 7'd0,  "f4_hist_80");
      rd(1'b0, 8'h10, 7'd0,  "f4_hist_10");
      rd(1'b0, 8'h20, 7'd0,  "f4_hist_20");
      rd(1'b0, 8'h00, 7'd0,  "f4_hist_00");
      rd(1'b1, 8'hFE, 7'd0,  "f4_cdf_fe");
      rd(1'b1, 8'hFF, 7'd64, "f4_cdf_ff");
      rd_idle();

      // Frame 5: start pulsed mid-ACCUM must be ignored
      for (int i = 0; i < 64; i++) pix[i] = 8'(i % 4);
      start_frame(1'b1);
      send(64, 1'b0, 30, 1'b1);
      wait_done(lat);
      chk("f5_latency", lat, 259);
      chk("f5_cdf_min", CDF_min, 16);
`ifdef HIST_ERR_EN
      chk("f5_hist_error_set", hist_error, 1);
`endif
      rd(1'b0, 8'h00, 7'd16, "f5_hist_00");
      rd(1'b0, 8'h03, 7'd16, "f5_hist_03");
      rd(1'b0, 8'h04, 7'd0,  "f5_hist_04");
      rd(1'b1, 8'h00, 7'd16, "f5_cdf_00");
      rd(1'b1, 8'h02, 7'd48, "f5_cdf_02");
      rd(1'b1, 8'h03, 7'd64, "f5_cdf_03");
      rd_idle();
      start_frame(1'b1);
`ifdef HIST_ERR_EN
      chk("f5_hist_error_clear", hist_error, 0);
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", q_exp.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
